// File: rtl/mmio_console.sv
// Avalon-MM console agent: TX byte FIFO drained to a paced valid/ready stream, plus a sticky EXIT register.
// Optional MMIO_CONSOLE_CYCLES_EN adds a clearable free-running cycle counter at offset 0x0C.
module mmio_console #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DRAIN_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [7:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] host_to_agent,
  output logic [31:0] agent_to_host,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        exit_valid,
  output logic [31:0] exit_code
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [15:0] GAP_INIT = 16'(DRAIN_DIV - 1);

  localparam logic [5:0] REG_TXDATA = 6'd0;
  localparam logic [5:0] REG_STATUS = 6'd1;
  localparam logic [5:0] REG_EXIT   = 6'd2;
  localparam logic [5:0] REG_CYCLES = 6'd3;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_e;

  logic [5:0]    word;
  logic          wr_acc, rd_acc;
  logic          push, pop, empty, full;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  state_e        state_q, state_d;
  logic [15:0]   gap_q, gap_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [31:0]   rdata_d, rdata_q;
  logic          rdv_q;
  logic          exit_valid_q;
  logic [31:0]   exit_code_q;
  logic          unused_addr;

  assign word        = address[7:2];
  assign unused_addr = ^address[1:0];

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));

  // A pop in the same cycle frees a slot, so a full-FIFO push is not stalled.
  assign waitrequest = sel & write & (word == REG_TXDATA) & byteenable[0] & full & ~pop;
  assign wr_acc      = sel & write & ~waitrequest;
  assign rd_acc      = sel & read & ~write;
  assign push        = wr_acc & (word == REG_TXDATA) & byteenable[0];

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop        = 1'b1;
        tx_data_d  = mem_q[rptr_q];
        tx_valid_d = 1'b1;
        state_d    = PRESENT;
      end
      PRESENT: if (tx_ready) begin
        if (DRAIN_DIV > 1) begin
          tx_valid_d = 1'b0;
          gap_d      = GAP_INIT;
          state_d    = GAP;
        end else if (!empty) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rptr_q];
        end else begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      GAP: if (gap_q == '0) begin
        if (!empty) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rptr_q];
          tx_valid_d = 1'b1;
          state_d    = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end else begin
        gap_d = gap_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MMIO_CONSOLE_CYCLES_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk) begin
    if (!rst)                                cyc_q <= '0;
    else if (wr_acc && word == REG_CYCLES)   cyc_q <= '0;
    else                                     cyc_q <= cyc_q + 32'd1;
  end
`endif

  always_comb begin
    rdata_d = '0;
    case (word)
      REG_STATUS: rdata_d = {exit_valid_q, 15'd0, 8'(count_q), 6'd0, full, empty};
      REG_EXIT:   rdata_d = exit_code_q;
`ifdef MMIO_CONSOLE_CYCLES_EN
      REG_CYCLES: rdata_d = cyc_q;
`endif
      default:    rdata_d = '0;
    endcase
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= host_to_agent[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      gap_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      rdata_q      <= '0;
      rdv_q        <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      state_q    <= state_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rdv_q      <= rd_acc;
      if (rd_acc) rdata_q <= rdata_d;
      if (wr_acc && word == REG_EXIT && |byteenable) begin
        exit_valid_q <= 1'b1;
        exit_code_q  <= host_to_agent;
      end
    end
  end

  assign agent_to_host = rdata_q;
  assign readdatavalid = rdv_q;
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign exit_valid    = exit_valid_q;
  assign exit_code     = exit_code_q;

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: reset, pacing, full-FIFO stall, tx stability, EXIT and CYCLES.
module tb_mmio_console;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel, read, write;
  logic [7:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] host_to_agent;
  logic [31:0] agent_to_host;
  logic        readdatavalid, waitrequest;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        exit_valid;
  logic [31:0] exit_code;

  int checks = 0;
  int errors = 0;

  mmio_console #(.FIFO_DEPTH(16), .DRAIN_DIV(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .host_to_agent(host_to_agent),
    .agent_to_host(agent_to_host), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .exit_valid(exit_valid), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  // Stream monitor: handshakes and valid rises are seen at negedge, ahead of the accepting posedge.
  int         cyc = 0;
  logic [7:0] got[$];
  int         rise[$];
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;
  int         stab_viol = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst === 1'b1) begin
      if (tx_valid === 1'b1 && !prev_v) rise.push_back(cyc);
      if (tx_valid === 1'b1 && tx_ready === 1'b1) got.push_back(tx_data);
      if (prev_v && !prev_r && (tx_valid !== 1'b1 || tx_data !== prev_d)) stab_viol <= stab_viol + 1;
      prev_v <= (tx_valid === 1'b1);
      prev_r <= (tx_ready === 1'b1);
      prev_d <= tx_data;
    end else begin
      prev_v <= 1'b0;
      prev_r <= 1'b0;
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    sel = 1'b1; write = 1'b1; read = 1'b0; address = a; byteenable = be; host_to_agent = d;
    #1;
    while (waitrequest === 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL bus_write_timeout addr=%h waitrequest stuck, required release within 200 cycles", a);
    end
    @(posedge clk); #1;
    sel = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic v, output logic v2);
    @(negedge clk);
    sel = 1'b1; read = 1'b1; write = 1'b0; address = a;
    @(posedge clk); #1;
    sel = 1'b0; read = 1'b0;
    d = agent_to_host; v = readdatavalid;
    @(posedge clk); #1;
    v2 = readdatavalid;
  endtask

  task automatic wait_beats(input int num, input int budget);
    int k = 0;
    while (got.size() < num && k < budget) begin
      @(negedge clk); k++;
    end
    checks++;
    if (got.size() < num) begin
      errors++;
      $display("FAIL beat_timeout got %0d beats, required %0d", got.size(), num);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v, v2;
    rst = 1'b0; sel = 1'b1; write = 1'b1; read = 1'b0; address = 8'h00;
    byteenable = 4'hF; host_to_agent = 32'h55; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (agent_to_host !== 32'h0) begin errors++; $display("FAIL rst_agent_to_host got %h want 0", agent_to_host); end
    checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_readdatavalid got %b want 0", readdatavalid); end
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL rst_waitrequest got %b want 0", waitrequest); end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin errors++; $display("FAIL rst_tx got v=%b d=%h want 0/00", tx_valid, tx_data); end
    checks++; if (exit_valid !== 1'b0 || exit_code !== 32'h0) begin errors++; $display("FAIL rst_exit got v=%b c=%h want 0/0", exit_valid, exit_code); end
    @(negedge clk);
    rst = 1'b1; sel = 1'b0; write = 1'b0;
    bus_read(8'h04, d, v, v2);
    checks++; if (d !== 32'h0000_0001 || v !== 1'b1) begin errors++; $display("FAIL rst_status got %h rdv=%b want 00000001 rdv=1", d, v); end
    checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL rdv_one_cycle got %b want 0", v2); end
    bus_read(8'h00, d, v, v2);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL txdata_read got %h rdv=%b want 0 rdv=1", d, v); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_no_push got tx_valid=%b want 0", tx_valid); end
  endtask

  task automatic test_drain();
    logic [31:0] d; logic v, v2;
    got.delete(); rise.delete();
    bus_write(8'h00, 32'h48, 4'h1);
    bus_write(8'h00, 32'h69, 4'h1);
    wait_beats(2, 60);
    checks++; if (got.size() < 2 || got[0] !== 8'h48 || got[1] !== 8'h69) begin errors++; $display("FAIL drain_bytes got %p want 48 69", got); end
    checks++; if (rise.size() < 2 || rise[1] - rise[0] != 5) begin errors++; $display("FAIL drain_pace got %p rise cycles want spacing 5", rise); end
    bus_read(8'h04, d, v, v2);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL drain_status got %h want 00000001", d); end
  endtask

  task automatic test_full_stall();
    logic [31:0] d; logic v, v2;
    int stalls = 0;
    int n = 0;
    @(posedge clk); #2; tx_ready = 1'b0;
    got.delete();
    // Byte 0 moves into the tx register, so 17 writes leave 16 in the FIFO.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      sel = 1'b1; write = 1'b1; address = 8'h00; byteenable = 4'h1; host_to_agent = 32'(i);
      #1; if (waitrequest !== 1'b0) stalls++;
      @(posedge clk); #1;
    end
    sel = 1'b0; write = 1'b0;
    checks++; if (stalls != 0) begin errors++; $display("FAIL fill_no_stall got %0d stalls want 0", stalls); end
    bus_read(8'h04, d, v, v2);
    checks++; if (d !== 32'h0000_1002) begin errors++; $display("FAIL full_status got %h want 00001002", d); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL full_head got v=%b d=%h want 1/00", tx_valid, tx_data); end
    @(negedge clk);
    sel = 1'b1; write = 1'b1; address = 8'h00; byteenable = 4'h1; host_to_agent = 32'h11;
    #1;
    checks++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL full_wait got %b want 1", waitrequest); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL full_wait_hold got %b want 1", waitrequest); end
    @(posedge clk); #2; tx_ready = 1'b1;
    @(posedge clk); #2; tx_ready = 1'b0;
    // Handshake leaves 3 gap cycles; the pop and the held push coincide after them.
    forever begin
      @(negedge clk); #1;
      if (waitrequest !== 1'b1 || n >= 20) break;
      n++;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL stall_release got %0d stalled cycles want 3", n); end
    @(posedge clk); #1;
    sel = 1'b0; write = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin errors++; $display("FAIL full_next got v=%b d=%h want 1/01", tx_valid, tx_data); end
    bus_read(8'h04, d, v, v2);
    checks++; if (d !== 32'h0000_1002) begin errors++; $display("FAIL full_count_kept got %h want 00001002", d); end
    @(posedge clk); #2; tx_ready = 1'b1;
    wait_beats(18, 400);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== 8'(i)) begin
        errors++; $display("FAIL full_order idx %0d got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, 8'(i));
      end
    end
  endtask

  task automatic test_random_ready();
    int base = stab_viol;
    got.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) bus_write(8'h00, 32'hA0 + 32'(i), 4'h1);
      end
      begin
        for (int k = 0; k < 600 && got.size() < 8; k++) begin
          @(posedge clk); #2; tx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #2; tx_ready = 1'b1;
    checks++; if (got.size() != 8) begin errors++; $display("FAIL rand_count got %0d want 8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++; if (got[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL rand_order idx %0d got %h want %h", i, got[i], 8'hA0 + 8'(i)); end
    end
    checks++; if (stab_viol != base) begin errors++; $display("FAIL tx_stable got %0d violations want 0", stab_viol - base); end
  endtask

  task automatic test_exit();
    logic [31:0] d; logic v, v2;
    @(negedge clk);
    sel = 1'b0; write = 1'b1; address = 8'h08; byteenable = 4'hF; host_to_agent = 32'hDEAD;
    @(posedge clk); #1; write = 1'b0;
    checks++; if (exit_valid !== 1'b0) begin errors++; $display("FAIL exit_nosel got %b want 0", exit_valid); end
    bus_write(8'h08, 32'h0000_002A, 4'h1);
    checks++; if (exit_valid !== 1'b1 || exit_code !== 32'h2A) begin errors++; $display("FAIL exit_set got v=%b c=%h want 1/0000002a", exit_valid, exit_code); end
    bus_read(8'h04, d, v, v2);
    checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL exit_status got %h want 80000001", d); end
    bus_write(8'h08, 32'h7, 4'h0);
    checks++; if (exit_code !== 32'h2A) begin errors++; $display("FAIL exit_no_be got %h want 0000002a", exit_code); end
    @(negedge clk);
    sel = 1'b1; read = 1'b1; write = 1'b1; address = 8'h08; byteenable = 4'h8; host_to_agent = 32'h55;
    @(posedge clk); #1; sel = 1'b0; read = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    checks++; if (readdatavalid !== 1'b0 || exit_code !== 32'h55) begin errors++; $display("FAIL rw_collide got rdv=%b c=%h want 0/00000055", readdatavalid, exit_code); end
    got.delete();
    bus_write(8'h00, 32'h21, 4'h1);
    wait_beats(1, 40);
    checks++; if (got.size() < 1 || got[0] !== 8'h21) begin errors++; $display("FAIL print_after_exit got %p want 21", got); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (exit_valid !== 1'b0 || exit_code !== 32'h0) begin errors++; $display("FAIL exit_reset got v=%b c=%h want 0/0", exit_valid, exit_code); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_cycles();
    logic [31:0] d; logic v, v2;
    bus_write(8'h0C, 32'h0, 4'hF);
    repeat (10) @(negedge clk);
    bus_read(8'h0C, d, v, v2);
`ifdef MMIO_CONSOLE_CYCLES_EN
    checks++; if (v !== 1'b1 || (d !== 32'd10 && d !== 32'd11)) begin errors++; $display("FAIL cycles got %0d rdv=%b want 10 or 11", d, v); end
`else
    checks++; if (v !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL cycles got %0d rdv=%b want 0", d, v); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_drain();
    test_full_stall();
    test_random_ready();
    test_exit();
    test_cycles();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
